// File: rtl/div_iter_unit_pkg.sv
// Shared divider definitions: operation codes, default width and the divider FSM state type.
package Parametros;

  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] ZERO = '0;

  localparam logic [4:0] OPDIV  = 5'd12;
  localparam logic [4:0] OPDIVU = 5'd13;
  localparam logic [4:0] OPREM  = 5'd14;
  localparam logic [4:0] OPREMU = 5'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } div_state_t;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OPDIV) || (op == OPDIVU) || (op == OPREM) || (op == OPREMU);
  endfunction

endpackage

// File: rtl/div_iter_unit_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Zero latency; no flow control.
module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_bit,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic            o_q
);

  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;

  // The partial remainder stays below the divisor, so the true difference fits in XLEN bits.
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift[XLEN-1:0] - i_div;
  assign o_q     = (w_shift >= {1'b0, i_div});
  assign o_rem   = o_q ? w_diff : w_shift[XLEN-1:0];

endmodule

// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider (DIV/DIVU/REM/REMU); oDone XLEN+2 clocks after start, oBusy stalls the core.
// DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and |A|<|B| skip the iteration phase.
module div_iter_unit #(
  parameter int XLEN = Parametros::XLEN
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic            iStart,
  input  logic            iKill,
  input  logic [4:0]      iControl,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oResult
);
  import Parametros::*;

  localparam int CW = $clog2(XLEN);

  div_state_t      r_state;
  logic [4:0]      r_op;
  logic [XLEN-1:0] r_a, r_b, r_div, r_q, r_rem, r_result;
  logic [CW-1:0]   r_cnt;
  logic            r_qneg, r_rneg, r_done;

  logic            w_signed, w_is_rem, w_a_neg, w_b_neg, w_b_zero, w_q_bit;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_rem_nxt, w_q_fix, w_r_fix, w_quot, w_remd;

  assign w_signed = (r_op == OPDIV) || (r_op == OPREM);
  assign w_is_rem = (r_op == OPREM) || (r_op == OPREMU);
  assign w_a_neg  = w_signed & r_a[XLEN-1];
  assign w_b_neg  = w_signed & r_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? (~r_a + 1'b1) : r_a;
  assign w_b_mag  = w_b_neg ? (~r_b + 1'b1) : r_b;
  assign w_b_zero = (r_b == '0);

  div_step #(.XLEN(XLEN)) u_step (
    .i_rem (r_rem),
    .i_bit (r_q[XLEN-1]),
    .i_div (r_div),
    .o_rem (w_rem_nxt),
    .o_q   (w_q_bit)
  );

  // Divide-by-zero bypasses the sign fix-up: quotient is all ones, remainder the raw dividend.
  assign w_q_fix = r_qneg ? (~r_q + 1'b1) : r_q;
  assign w_r_fix = r_rneg ? (~r_rem + 1'b1) : r_rem;
  assign w_quot  = w_b_zero ? '1 : w_q_fix;
  assign w_remd  = w_b_zero ? r_a : w_r_fix;

`ifdef DIV_EARLY_OUT_EN
  logic w_ovf, w_early;
  assign w_ovf   = w_signed && (r_a == {1'b1, {(XLEN-1){1'b0}}}) && (r_b == '1);
  assign w_early = w_b_zero || w_ovf || (w_a_mag < w_b_mag);
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_div    <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (iStart && is_div_op(iControl)) begin
            r_op    <= iControl;
            r_a     <= iA;
            r_b     <= iB;
            r_state <= PREP;
          end
        end
        PREP: begin
          if (iKill) begin
            r_state <= IDLE;
          end else begin
            r_div  <= w_b_mag;
            r_q    <= w_a_mag;
            r_rem  <= '0;
            r_qneg <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
            r_cnt  <= CW'(XLEN - 1);
`ifdef DIV_EARLY_OUT_EN
            if (w_early) begin
              r_q     <= w_ovf ? w_a_mag : '0;
              r_rem   <= w_ovf ? '0 : w_a_mag;
              r_state <= FIX;
            end else begin
              r_state <= ITER;
            end
`else
            r_state <= ITER;
`endif
          end
        end
        ITER: begin
          if (iKill) begin
            r_state <= IDLE;
          end else begin
            r_rem <= w_rem_nxt;
            r_q   <= {r_q[XLEN-2:0], w_q_bit};
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) r_state <= FIX;
          end
        end
        FIX: begin
          if (iKill) begin
            r_state <= IDLE;
          end else begin
            r_result <= w_is_rem ? w_remd : w_quot;
            r_done   <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oBusy   = (r_state != IDLE);
  assign oDone   = r_done;
  assign oResult = r_result;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed self-checking bench for div_iter_unit (default build, XLEN=64).
module tb_div_iter_unit;
  import Parametros::*;

  logic        iCLK = 1'b0;
  logic        iRST_N, iStart, iKill;
  logic [4:0]  iControl;
  logic [63:0] iA, iB;
  logic        oBusy, oDone;
  logic [63:0] oResult;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 iCLK = ~iCLK;

  div_iter_unit #(.XLEN(64)) dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iStart   (iStart),
    .iKill    (iKill),
    .iControl (iControl),
    .iA       (iA),
    .iB       (iB),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oResult  (oResult)
  );

  // Issue one op from the current cycle and wait (bounded) for oDone; operands are scrambled after the start edge.
  task automatic run_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat, output int busy);
    iStart = 1'b1; iControl = op; iA = a; iB = b;
    @(posedge iCLK); #1;
    iStart = 1'b0; iA = {$urandom, $urandom}; iB = {$urandom, $urandom};
    busy = oBusy ? 1 : 0;
    lat  = 0;
    res  = 'x;
    while (lat < 200) begin
      @(posedge iCLK); #1;
      lat++;
      if (oBusy) busy++;
      if (oDone) begin
        res = oResult;
        break;
      end
    end
  endtask

  task automatic test_reset();
    iRST_N = 1'b0; iStart = 1'b1; iKill = 1'b0; iControl = OPDIVU; iA = 64'd100; iB = 64'd7;
    repeat (3) @(posedge iCLK);
    #1;
    n_vec++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", oBusy); end
    n_vec++; if (oDone !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", oDone); end
    n_vec++; if (oResult !== ZERO) begin n_fail++; $display("FAIL reset_result: got %h expected %h", oResult, ZERO); end
    iStart = 1'b0;
    @(negedge iCLK); iRST_N = 1'b1;
    @(posedge iCLK); #1;
  endtask

  task automatic test_bad_op();
    iStart = 1'b1; iControl = 5'd0; iA = 64'd100; iB = 64'd7;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    n_vec++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL bad_op_ignored: busy got %b expected 0", oBusy); end
  endtask

  task automatic test_unsigned();
    logic [63:0] res; int lat, busy;
    run_op(OPDIVU, 64'd100, 64'd7, res, lat, busy);
    n_vec++; if (res !== 64'd14) begin n_fail++; $display("FAIL divu_100_7: got %h expected %h", res, 64'd14); end
    n_vec++; if (lat !== 66) begin n_fail++; $display("FAIL divu_latency: got %0d expected 66", lat); end
    n_vec++; if (busy !== 66) begin n_fail++; $display("FAIL divu_busy_cycles: got %0d expected 66", busy); end
    @(posedge iCLK); #1;
    n_vec++; if (oDone !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b expected 0", oDone); end
    n_vec++; if (oResult !== 64'd14) begin n_fail++; $display("FAIL result_hold: got %h expected %h", oResult, 64'd14); end
    run_op(OPREMU, 64'd100, 64'd7, res, lat, busy);
    n_vec++; if (res !== 64'd2) begin n_fail++; $display("FAIL remu_100_7: got %h expected %h", res, 64'd2); end
    n_vec++; if (lat !== 66) begin n_fail++; $display("FAIL remu_latency: got %0d expected 66", lat); end
    run_op(OPDIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, res, lat, busy);
    n_vec++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL divu_max_1: got %h expected all ones", res); end
    run_op(OPREMU, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat, busy);
    n_vec++; if (res !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL remu_big: got %h expected %h", res, 64'h8000_0000_0000_0000); end
  endtask

  task automatic test_signed();
    logic [4:0]  ops [6] = '{OPDIV, OPREM, OPREM, OPDIV, OPDIV, OPREM};
    logic [63:0] as  [6] = '{64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FF9C, 64'd100,
                             64'd100, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FF9C};
    logic [63:0] bs  [6] = '{64'd7, 64'd7, 64'hFFFF_FFFF_FFFF_FFF9,
                             64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9};
    logic [63:0] exp [6] = '{64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2,
                             64'hFFFF_FFFF_FFFF_FFF2, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE};
    logic [63:0] res; int lat, busy;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, busy);
      n_vec++;
      if (res !== exp[i]) begin n_fail++; $display("FAIL signed_%0d: got %h expected %h", i, res, exp[i]); end
    end
  endtask

  task automatic test_div_zero();
    logic [4:0]  ops [5] = '{OPDIV, OPREMU, OPDIVU, OPREM, OPDIV};
    logic [63:0] as  [5] = '{64'd5, 64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB};
    logic [63:0] exp [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] res; int lat, busy;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], 64'd0, res, lat, busy);
      n_vec++;
      if (res !== exp[i]) begin n_fail++; $display("FAIL div_zero_%0d: got %h expected %h", i, res, exp[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] res; int lat, busy;
    run_op(OPDIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat, busy);
    n_vec++; if (res !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL ovf_div: got %h expected %h", res, 64'h8000_0000_0000_0000); end
    run_op(OPREM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat, busy);
    n_vec++; if (res !== 64'd0) begin n_fail++; $display("FAIL ovf_rem: got %h expected 0", res); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res; int lat, busy;
    run_op(OPDIVU, 64'd1000, 64'd3, res, lat, busy);
    n_vec++; if (res !== 64'd333) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", res, 64'd333); end
    run_op(OPREMU, 64'd1000, 64'd3, res, lat, busy);
    n_vec++; if (res !== 64'd1) begin n_fail++; $display("FAIL b2b_second: got %h expected 1", res); end
    n_vec++; if (lat !== 66) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 66", lat); end
  endtask

  task automatic test_kill();
    logic [63:0] res, first_res; int lat, busy, dones, first_lat;
    run_op(OPDIVU, 64'd100, 64'd7, res, lat, busy);
    n_vec++; if (res !== 64'd14) begin n_fail++; $display("FAIL kill_setup: got %h expected %h", res, 64'd14); end
    iStart = 1'b1; iControl = OPDIVU; iA = 64'd1000; iB = 64'd3;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    dones = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 5 || k == 10) begin iStart = 1'b1; iControl = OPDIVU; iA = 64'd9; iB = 64'd3; end
      if (k == 10) iKill = 1'b1;
      @(posedge iCLK); #1;
      iStart = 1'b0; iKill = 1'b0;
      if (oDone) dones++;
    end
    n_vec++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL kill_busy: got %b expected 0", oBusy); end
    n_vec++; if (oResult !== 64'd14) begin n_fail++; $display("FAIL kill_result_kept: got %h expected %h", oResult, 64'd14); end
    repeat (80) begin @(posedge iCLK); #1; if (oDone) dones++; end
    n_vec++; if (dones !== 0) begin n_fail++; $display("FAIL kill_no_done: got %0d pulses expected 0", dones); end
    n_vec++; if (oResult !== 64'd14) begin n_fail++; $display("FAIL kill_result_late: got %h expected %h", oResult, 64'd14); end

    // A start presented mid-operation must neither restart nor queue.
    iStart = 1'b1; iControl = OPDIVU; iA = 64'd1000; iB = 64'd3;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    dones = 0; first_lat = 0; first_res = 'x;
    for (int k = 1; k <= 160; k++) begin
      if (k == 5) begin iStart = 1'b1; iControl = OPDIVU; iA = 64'd9; iB = 64'd3; end
      @(posedge iCLK); #1;
      iStart = 1'b0;
      if (oDone) begin
        dones++;
        if (dones == 1) begin first_lat = k; first_res = oResult; end
      end
    end
    n_vec++; if (dones !== 1) begin n_fail++; $display("FAIL busy_start_pulses: got %0d expected 1", dones); end
    n_vec++; if (first_res !== 64'd333) begin n_fail++; $display("FAIL busy_start_result: got %h expected %h", first_res, 64'd333); end
    n_vec++; if (first_lat !== 66) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 66", first_lat); end
  endtask

  task automatic test_reset_midop();
    logic [63:0] res; int lat, busy;
    run_op(OPDIVU, 64'd50, 64'd5, res, lat, busy);
    n_vec++; if (res !== 64'd10) begin n_fail++; $display("FAIL rst_setup: got %h expected %h", res, 64'd10); end
    iStart = 1'b1; iControl = OPDIVU; iA = 64'd1000; iB = 64'd3;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    repeat (30) @(posedge iCLK);
    #1;
    iRST_N = 1'b0;
    #1;
    n_vec++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", oBusy); end
    n_vec++; if (oDone !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", oDone); end
    n_vec++; if (oResult !== ZERO) begin n_fail++; $display("FAIL rst_mid_result: got %h expected 0", oResult); end
    repeat (2) @(posedge iCLK);
    @(negedge iCLK); iRST_N = 1'b1;
    @(posedge iCLK); #1;
    run_op(OPDIVU, 64'd9, 64'd3, res, lat, busy);
    n_vec++; if (res !== 64'd3) begin n_fail++; $display("FAIL rst_after_result: got %h expected 3", res); end
    n_vec++; if (lat !== 66) begin n_fail++; $display("FAIL rst_after_latency: got %0d expected 66", lat); end
  endtask

  initial begin
    test_reset();
    test_bad_op();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_kill();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
